// File: rtl/audio_mixer_nch.sv
// N-channel time-multiplexed audio mixer: per-channel gain/mute, master volume, saturation, valid/ready output.
// Optional sticky clip flag enabled by defining MIXER_CLIP_DETECT_EN.
module audio_mixer_nch #(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CH*SAMPLE_BITS-1:0]       in_samples,
  input  logic [NUM_CH*VOLUME_BITS-1:0]       ch_gain,
  input  logic [NUM_CH-1:0]                   ch_mute,
  input  logic [VOLUME_BITS-1:0]              master_vol,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [SAMPLE_BITS-1:0]       out_sample,
  input  logic                                clip_clr,
  output logic                                clip_sticky
);

  localparam int KW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = SAMPLE_BITS + VOLUME_BITS + $clog2(NUM_CH) + 1;
  localparam int SCL_W = ACC_W + VOLUME_BITS + 1;
  localparam int SH    = VOLUME_BITS - 1;

  localparam logic [KW-1:0] K_LAST = KW'(NUM_CH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACCUM = 3'd1;
  localparam logic [2:0] ST_SCALE = 3'd2;
  localparam logic [2:0] ST_SAT   = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  localparam logic signed [SCL_W-1:0] MAXV = SCL_W'($signed({1'b0, {(SAMPLE_BITS-1){1'b1}}}));
  localparam logic signed [SCL_W-1:0] MINV = SCL_W'($signed({1'b1, {(SAMPLE_BITS-1){1'b0}}}));

  function automatic logic is_clip(input logic signed [SCL_W-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [SAMPLE_BITS-1:0] sat_sample(input logic signed [SCL_W-1:0] v);
    if (v > MAXV)      return MAXV[SAMPLE_BITS-1:0];
    else if (v < MINV) return MINV[SAMPLE_BITS-1:0];
    else               return v[SAMPLE_BITS-1:0];
  endfunction

  logic [2:0]                       state;
  logic [KW-1:0]                    k_p0;
  logic [NUM_CH*SAMPLE_BITS-1:0]    samples_p0;
  logic [NUM_CH*VOLUME_BITS-1:0]    gain_p0;
  logic [NUM_CH-1:0]                mute_p0;
  logic [VOLUME_BITS-1:0]           master_p0;
  logic signed [ACC_W-1:0]          acc_p1;
  logic signed [SCL_W-1:0]          scaled_p2;

  logic signed [SAMPLE_BITS-1:0]    smp_arr [NUM_CH];
  logic [VOLUME_BITS-1:0]           gain_arr [NUM_CH];
  logic signed [ACC_W-1:0]          term;
  logic signed [ACC_W-1:0]          mix;
  logic signed [SCL_W-1:0]          prod;
  logic signed [SCL_W-1:0]          scl_w;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      smp_arr[i]  = samples_p0[i*SAMPLE_BITS +: SAMPLE_BITS];
      gain_arr[i] = gain_p0[i*VOLUME_BITS +: VOLUME_BITS];
    end
  end

  // Stage p1: one weighted channel per cycle into the accumulator
  always_comb begin
    term = '0;
    if (!mute_p0[k_p0])
      term = ACC_W'(smp_arr[k_p0]) * ACC_W'($signed({1'b0, gain_arr[k_p0]}));
  end

  // Stage p2: unity-normalise the mix, then apply master volume (floor shifts)
  always_comb begin
    mix   = acc_p1 >>> SH;
    prod  = SCL_W'(mix) * SCL_W'($signed({1'b0, master_p0}));
    scl_w = prod >>> SH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      k_p0       <= '0;
      acc_p1     <= '0;
      out_sample <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state  <= ST_ACCUM;
            k_p0   <= '0;
            acc_p1 <= '0;
          end
        end
        ST_ACCUM: begin
          acc_p1 <= acc_p1 + term;
          if (k_p0 == K_LAST) state <= ST_SCALE;
          else                k_p0  <= k_p0 + KW'(1);
        end
        ST_SCALE: state <= ST_SAT;
        ST_SAT: begin
          out_sample <= sat_sample(scaled_p2);
          state      <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: latched input set; in-flight mix is immune to input changes
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      samples_p0 <= in_samples;
      gain_p0    <= ch_gain;
      mute_p0    <= ch_mute;
      master_p0  <= master_vol;
    end
    if (state == ST_SCALE) scaled_p2 <= scl_w;
  end

`ifdef MIXER_CLIP_DETECT_EN
  // Set has priority over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      clip_sticky <= 1'b0;
    else if (state == ST_SAT && is_clip(scaled_p2))
      clip_sticky <= 1'b1;
    else if (clip_clr)
      clip_sticky <= 1'b0;
  end
`else
  logic unused_clip_clr;
  assign unused_clip_clr = clip_clr;
  assign clip_sticky     = 1'b0;
`endif

endmodule
